// File: rtl/reg_arb_pkg.sv
// Shared encodings and default widths for the register-file access arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_WAIT = 2'd2
    } stateT;

    localparam logic PORT_I2C  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_RW   = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic. REG_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// otherwise port 0 always wins a tie.
module rr_arb2
    import reg_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic gnt,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef REG_ARB_ROUND_ROBIN_EN
    // On a tie the port that did not win last time goes next.
    always_comb begin
        gnt = PORT_I2C;
        if (req0 && req1) gnt = ~lastGrant;
        else if (req1)    gnt = PORT_HOST;
    end
`else
    logic unusedLastGrant;
    assign unusedLastGrant = lastGrant;

    always_comb begin
        gnt = PORT_I2C;
        if (req1 && !req0) gnt = PORT_HOST;
    end
`endif

endmodule

// File: rtl/reg_access_arbiter.sv
// Serialises I2C-slave and host accesses onto the single-port register file,
// range-checks them and returns registered ack/err/rdata. Tie policy: REG_ARB_ROUND_ROBIN_EN.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RW   = DEF_NUM_RW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] ri_addr,
    output logic [DATA_W-1:0] ri_dataIn,
    output logic              ri_writeEn,
    input  logic [DATA_W-1:0] ri_dataOut,
    output logic              busy,
    output logic              grant
);

    stateT             state, stateNext;
    logic              lastGrant;
    logic              weQ, errQ;
    logic              arbGnt, arbValid;
    logic              latchReq, finishAcc;
    logic              selWe, selErr;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    function automatic logic rangeErr(input logic [ADDR_W-1:0] addr, input logic we);
        return (addr >= ADDR_W'(NUM_REGS)) || (we && (addr >= ADDR_W'(NUM_RW)));
    endfunction

    // A port whose ack is showing this cycle is not eligible: that req belongs to
    // the access just completed.
    rr_arb2 u_arb (
        .req0      (r0_req & ~r0_ack),
        .req1      (r1_req & ~r1_ack),
        .lastGrant (lastGrant),
        .gnt       (arbGnt),
        .valid     (arbValid)
    );

    always_comb begin
        selWe    = r0_we;
        selAddr  = r0_addr;
        selWdata = r0_wdata;
        if (arbGnt == PORT_HOST) begin
            selWe    = r1_we;
            selAddr  = r1_addr;
            selWdata = r1_wdata;
        end
        selErr = rangeErr(selAddr, selWe);
    end

    always_comb begin
        stateNext = state;
        latchReq  = 1'b0;
        finishAcc = 1'b0;
        unique case (state)
            ST_IDLE: if (arbValid) begin
                latchReq  = 1'b1;
                stateNext = ST_ACC;
            end
            ST_ACC:  stateNext = ST_WAIT;
            ST_WAIT: begin
                finishAcc = 1'b1;
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lastGrant  <= PORT_HOST;
            grant      <= PORT_I2C;
            weQ        <= 1'b0;
            errQ       <= 1'b0;
            busy       <= 1'b0;
            ri_addr    <= '0;
            ri_dataIn  <= '0;
            ri_writeEn <= 1'b0;
            r0_ack     <= 1'b0;
            r0_err     <= 1'b0;
            r0_rdata   <= '0;
            r1_ack     <= 1'b0;
            r1_err     <= 1'b0;
            r1_rdata   <= '0;
        end else begin
            state      <= stateNext;
            busy       <= (stateNext != ST_IDLE);
            ri_writeEn <= 1'b0;
            r0_ack     <= 1'b0;
            r0_err     <= 1'b0;
            r1_ack     <= 1'b0;
            r1_err     <= 1'b0;
            if (latchReq) begin
                grant      <= arbGnt;
                lastGrant  <= arbGnt;
                weQ        <= selWe;
                errQ       <= selErr;
                ri_addr    <= selAddr;
                ri_dataIn  <= selWdata;
                ri_writeEn <= selWe && !selErr;
            end
            // Writes leave rdata alone; failed reads return zero.
            if (finishAcc) begin
                if (grant == PORT_HOST) begin
                    r1_ack <= 1'b1;
                    r1_err <= errQ;
                    if (!weQ) r1_rdata <= errQ ? '0 : ri_dataOut;
                end else begin
                    r0_ack <= 1'b1;
                    r0_err <= errQ;
                    if (!weQ) r0_rdata <= errQ ? '0 : ri_dataOut;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed and randomized check of reg_access_arbiter against a transaction-level model.
module tb_reg_access_arbiter;

`ifdef REG_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic       r0_ack, r0_err, r1_ack, r1_err;
    logic [7:0] r0_rdata, r1_rdata;
    logic [7:0] ri_addr, ri_dataIn, ri_dataOut;
    logic       ri_writeEn, busy, grant;

    int passCnt = 0;
    int failCnt = 0;
    int checkCnt = 0;

    always #5 clk = ~clk;

    reg_access_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .ri_addr(ri_addr), .ri_dataIn(ri_dataIn), .ri_writeEn(ri_writeEn),
        .ri_dataOut(ri_dataOut), .busy(busy), .grant(grant)
    );

    // Register file stand-in: registered read, 1-cycle latency, never reset.
    function automatic logic [7:0] initVal(input logic [7:0] a);
        case (a)
            8'd0: return 8'h03;
            8'd1: return 8'h13;
            8'd2: return 8'h23;
            8'd3: return 8'h33;
            8'd4: return 8'h11;
            8'd5: return 8'h3C;
            8'd6: return 8'h5A;
            8'd7: return 8'h96;
            default: return 8'hEE;
        endcase
    endfunction

    logic [7:0] fileMem [256];
    logic       tbInit;
    always @(posedge clk) begin
        if (tbInit) for (int i = 0; i < 256; i++) fileMem[i] <= initVal(8'(i));
        else if (ri_writeEn) fileMem[ri_addr] <= ri_dataIn;
        ri_dataOut <= fileMem[ri_addr];
    end

    // Architectural model: register contents as seen by completed accesses.
    logic [7:0] refMem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input bit p, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wd);
        if (p) begin r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd; end
        else   begin r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd; end
    endtask

    function automatic bit expErrOf(input logic we, input logic [7:0] a);
        return (a >= 8) || (we && a >= 4);
    endfunction

    bit         pend[2], pWe[2], isAck, isErr, eErr, prevWe;
    int         age[2];
    logic [7:0] pAddr[2], pWd[2], expRd[2], rd;

    initial begin
        rst = 1'b1; tbInit = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) refMem[i] = initVal(8'(i));
        step(); step();
        chk("rst_outs_a", 32'({r0_ack, r0_err, r0_rdata, r1_ack, r1_err, r1_rdata}), 0);
        chk("rst_outs_b", 32'({ri_addr, ri_dataIn, ri_writeEn, busy, grant}), 0);
        rst = 1'b0; tbInit = 1'b0;
        step();

        // Port 0 writes 0xA5 to addr 2
        drive(0, 1, 1, 8'd2, 8'hA5);
        step();
        chk("t1_we_pulse", 32'({ri_writeEn, ri_addr, ri_dataIn}), {1'b1, 8'd2, 8'hA5});
        chk("t1_busy_grant", 32'({busy, grant, r0_ack}), 3'b100);
        step();
        chk("t1_we_drop", 32'(ri_writeEn), 0);
        step();
        chk("t1_ack", 32'({r0_ack, r0_err, r1_ack}), 3'b100);
        refMem[2] = 8'hA5;
        drive(0, 0, 0, 8'd0, 8'd0);
        step();
        chk("t1_ack_1cyc", 32'({r0_ack, busy}), 0);

        // Port 1 reads status addr 5
        drive(1, 1, 0, 8'd5, 8'h00);
        step(); step();
        chk("t2_no_early_ack", 32'({r0_ack, r1_ack}), 0);
        step();
        chk("t2_ack", 32'({r1_ack, r1_err, r1_rdata, r0_ack, grant}), {1'b1, 1'b0, 8'h3C, 1'b0, 1'b1});
        drive(1, 0, 0, 8'd0, 8'd0);
        step();

        // Write to read-only addr 6, then good read, then out-of-range read
        drive(0, 1, 1, 8'd6, 8'hFF);
        step();
        chk("t4_ro_no_we", 32'({ri_writeEn, busy}), 2'b01);
        step(); step();
        chk("t4_ro_err", 32'({r0_ack, r0_err}), 2'b11);
        drive(0, 0, 0, 8'd0, 8'd0);
        step();
        drive(0, 1, 0, 8'd2, 8'h00);
        repeat (3) step();
        chk("t4_read2", 32'({r0_ack, r0_err, r0_rdata}), {1'b1, 1'b0, 8'hA5});
        drive(0, 0, 0, 8'd0, 8'd0);
        step();
        drive(0, 1, 0, 8'h20, 8'h00);
        repeat (3) step();
        chk("t4_oor_read", 32'({r0_ack, r0_err, r0_rdata}), {1'b1, 1'b1, 8'h00});
        drive(0, 0, 0, 8'd0, 8'd0);
        step();

        // Req held one cycle past ack is a second access
        drive(0, 1, 0, 8'd0, 8'h00);
        repeat (3) step();
        chk("t6_ack1", 32'({r0_ack, r0_rdata}), {1'b1, 8'h03});
        step();
        chk("t6_gap", 32'({r0_ack, busy}), 0);
        step();
        chk("t6_restart", 32'({busy, grant}), 2'b10);
        step(); step();
        chk("t6_ack2", 32'({r0_ack, r0_err, r0_rdata}), {1'b1, 1'b0, 8'h03});
        drive(0, 0, 0, 8'd0, 8'd0);
        step();

        // Reset in the middle of a write to addr 1
        drive(0, 1, 1, 8'd1, 8'h77);
        step();
        chk("t5_we_before", 32'(ri_writeEn), 1);
        #2 rst = 1'b1;
        #1 chk("t5_we_async", 32'({ri_writeEn, busy}), 0);
        drive(0, 0, 0, 8'd0, 8'd0);
        step();
        rst = 1'b0;
        step();
        chk("t5_outs_a", 32'({r0_ack, r0_err, r0_rdata, r1_ack, r1_err, r1_rdata}), 0);
        chk("t5_outs_b", 32'({ri_addr, ri_dataIn, ri_writeEn, busy, grant}), 0);
        chk("t5_not_committed", 32'(fileMem[1]), 32'(refMem[1]));

        // Both ports held: ack-cycle masking hands the slot to the other port
        drive(0, 1, 0, 8'd0, 8'h00);
        drive(1, 1, 0, 8'd4, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t3_ack0", 32'(r0_ack), 32'((k % 6) == 3));
            chk("t3_ack1", 32'(r1_ack), 32'((k % 6) == 0));
        end
        drive(0, 0, 0, 8'd0, 8'd0);
        drive(1, 0, 0, 8'd0, 8'd0);
        step();
        // Port 0 served last, then a fresh tie: only round-robin favours port 1
        drive(0, 1, 0, 8'd0, 8'h00);
        repeat (3) step();
        drive(0, 0, 0, 8'd0, 8'd0);
        step();
        drive(0, 1, 0, 8'd0, 8'h00);
        drive(1, 1, 0, 8'd4, 8'h00);
        repeat (3) step();
        chk("t3_tie_winner", 32'({r0_ack, r1_ack}), 32'({~RR, RR}));
        drive(0, 0, 0, 8'd0, 8'd0);
        drive(1, 0, 0, 8'd0, 8'd0);
        step();

        // Randomized traffic on both ports against the transaction model
        expRd[0] = 8'h03;
        expRd[1] = 8'h11;
        pend[0] = 0; pend[1] = 0;
        prevWe = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (ri_writeEn) begin
                chk("rnd_we_legal", 32'(ri_addr < 4), 1);
                chk("rnd_we_single", 32'(prevWe), 0);
            end
            prevWe = ri_writeEn;
            for (int p = 0; p < 2; p++) begin
                isAck = p ? r1_ack : r0_ack;
                isErr = p ? r1_err : r0_err;
                rd    = p ? r1_rdata : r0_rdata;
                if (pend[p]) begin
                    age[p]++;
                    if (isAck) begin
                        eErr = expErrOf(pWe[p], pAddr[p]);
                        if (!pWe[p]) expRd[p] = eErr ? 8'h00 : refMem[pAddr[p]];
                        else if (!eErr) refMem[pAddr[p]] = pWd[p];
                        chk("rnd_err", 32'(isErr), 32'(eErr));
                        chk("rnd_rdata", 32'(rd), 32'(expRd[p]));
                        chk("rnd_latency_min", 32'(age[p] >= 3), 1);
                        pend[p] = 0;
                    end else if (age[p] > 12) begin
                        chk("rnd_timeout", 32'(age[p]), 12);
                        pend[p] = 0;
                    end
                end else begin
                    chk("rnd_no_spurious_ack", 32'(isAck), 0);
                end
                if (!pend[p]) begin
                    if ($urandom_range(3) != 0) begin
                        pend[p]  = 1;
                        age[p]   = 0;
                        pWe[p]   = 1'($urandom_range(1));
                        pAddr[p] = ($urandom_range(7) == 0) ? 8'($urandom_range(255, 8))
                                                            : 8'($urandom_range(7));
                        pWd[p]   = 8'($urandom);
                        drive(p[0], 1, pWe[p], pAddr[p], pWd[p]);
                    end else begin
                        drive(p[0], 0, 0, 8'd0, 8'd0);
                    end
                end
            end
        end
        drive(0, 0, 0, 8'd0, 8'd0);
        drive(1, 0, 0, 8'd0, 8'd0);
        repeat (6) step();
        for (int i = 0; i < 8; i++) chk("end_file_contents", 32'(fileMem[i]), 32'(refMem[i]));

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
